transmitter_fsm: RTL and testbench

UART serial transmitter: the stage directly upstream of `receiver_fsm` on the serial line. It accepts a parallel byte with a one-cycle start strobe and serialises it LSB-first as start bit, 7 or 8 data bits, optional parity and 1 or 2 stop bits. Each bit is held for 16 `bd_tick` pulses, the same 16x oversampling baud tick the receiver consumes. Frame format inputs match `receiver_fsm` exactly, so a TX→RX loopback with identical settings reproduces the byte with no flags raised.

---
 rtl/uart_pkg.sv | 18 +
 rtl/transmitter_fsm.sv | 159 +++++++++++++++
 tb/tb_transmitter_fsm.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and oversampling.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/transmitter_fsm.sv
// UART serial transmitter: start bit, 7/8 data bits LSB-first, optional
// parity, 1/2 stop bits, each bit held for OVERSAMPLE baud ticks.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | line high, waiting for tx_start
// ST_START  | driving the start bit (low)
// ST_DATA   | driving shift[0]; n_cnt is the data bit index
// ST_PARITY | driving the parity bit latched at acceptance
// ST_STOP   | driving stop bit(s); n_cnt counts stop bits
module transmitter_fsm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bd_tick,
  input  logic       tx_start,
  input  logic [7:0] d_in,
  input  logic       D_num,
  input  logic       S_num,
  input  logic [1:0] Par,
  output logic       tx,
  output logic       tx_done,
  output logic       is_active
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] S_LAST = CW'(OVERSAMPLE - 1);

  uart_state_t state, state_nxt;
  logic [CW-1:0] s_cnt, s_cnt_nxt;
  logic [2:0]    n_cnt, n_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          par_bit, par_bit_nxt;
  logic          d_num_q, d_num_nxt;
  logic          s_num_q, s_num_nxt;
  logic [1:0]    par_q, par_nxt;
  logic          tx_nxt, done_nxt;
  logic          bit_end;
  logic          has_par;
  logic [2:0]    last_bit;
  logic [7:0]    d_masked;

  assign bit_end   = bd_tick && (s_cnt == S_LAST);
  assign has_par   = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign last_bit  = d_num_q ? 3'd7 : 3'd6;
  assign d_masked  = {D_num & d_in[7], d_in[6:0]};
  assign is_active = (state != ST_IDLE);

  // State register plus frame datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      s_cnt   <= '0;
      n_cnt   <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      d_num_q <= 1'b0;
      s_num_q <= 1'b0;
      par_q   <= PAR_NONE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_cnt   <= s_cnt_nxt;
      n_cnt   <= n_cnt_nxt;
      shift   <= shift_nxt;
      par_bit <= par_bit_nxt;
      d_num_q <= d_num_nxt;
      s_num_q <= s_num_nxt;
      par_q   <= par_nxt;
      tx      <= tx_nxt;
      tx_done <= done_nxt;
    end
  end

  // Next-state logic: bit timing, bit sequencing and frame acceptance.
  always_comb begin
    state_nxt   = state;
    s_cnt_nxt   = s_cnt;
    n_cnt_nxt   = n_cnt;
    shift_nxt   = shift;
    par_bit_nxt = par_bit;
    d_num_nxt   = d_num_q;
    s_num_nxt   = s_num_q;
    par_nxt     = par_q;
    done_nxt    = 1'b0;

    if ((state != ST_IDLE) && bd_tick)
      s_cnt_nxt = bit_end ? '0 : s_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped on purpose.
        if (tx_start && !tx_done) begin
          state_nxt   = ST_START;
          s_cnt_nxt   = '0;
          n_cnt_nxt   = '0;
          shift_nxt   = d_masked;
          par_bit_nxt = (^d_masked) ^ (Par == PAR_ODD);
          d_num_nxt   = D_num;
          s_num_nxt   = S_num;
          par_nxt     = Par;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          n_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (n_cnt == last_bit) begin
            state_nxt = has_par ? ST_PARITY : ST_STOP;
            n_cnt_nxt = '0;
          end else begin
            n_cnt_nxt = n_cnt + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt = ST_STOP;
          n_cnt_nxt = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (s_num_q && (n_cnt == 3'd0)) begin
            n_cnt_nxt = 3'd1;
          end else begin
            state_nxt = ST_IDLE;
            n_cnt_nxt = '0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so tx leaves a flop glitch-free.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      ST_IDLE:   tx_nxt = 1'b1;
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_nxt[0];
      ST_PARITY: tx_nxt = par_bit_nxt;
      ST_STOP:   tx_nxt = 1'b1;
      default:   tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_transmitter_fsm.sv
// Testbench for transmitter_fsm: frame-level reference model feeding a
// scoreboard, with an independent line monitor sampling tx on baud ticks.
module tb_transmitter_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bd_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       D_num = 1'b0;
  logic       S_num = 1'b0;
  logic [1:0] Par = 2'b00;
  logic       tx;
  logic       tx_done;
  logic       is_active;

  int n_vec = 0;
  int n_err = 0;
  int tick_div = 4;   // 0 = random ticks, else one tick every tick_div clk

  bit exp_bits[$];
  int exp_len[$];

  transmitter_fsm #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .tx_start(tx_start),
    .d_in(d_in), .D_num(D_num), .S_num(S_num), .Par(Par),
    .tx(tx), .tx_done(tx_done), .is_active(is_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the line levels of one frame, one entry per bit period.
  task automatic push_frame(input logic [7:0] d, input logic dn, input logic sn,
                            input logic [1:0] p);
    int nb;
    int ndata;
    bit pb;
    ndata = dn ? 8 : 7;
    nb = 0;
    exp_bits.push_back(1'b0); nb++;
    pb = 1'b0;
    for (int i = 0; i < ndata; i++) begin
      exp_bits.push_back(d[i]); nb++;
      pb = pb ^ d[i];
    end
    if (p == 2'b01 || p == 2'b10) begin
      exp_bits.push_back((p == 2'b10) ? ~pb : pb); nb++;
    end
    for (int i = 0; i < (sn ? 2 : 1); i++) begin
      exp_bits.push_back(1'b1); nb++;
    end
    exp_len.push_back(nb * 16);
  endtask

  // Call at posedge+#1 with the DUT idle; returns one cycle after acceptance.
  task automatic send(input logic [7:0] d, input logic dn, input logic sn,
                      input logic [1:0] p);
    push_frame(d, dn, sn, p);
    d_in = d; D_num = dn; S_num = sn; Par = p;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("accept_active", is_active, 1);
    check("accept_tx_low", tx, 0);
    // Mid-frame format changes must not affect the frame in flight.
    d_in = 8'($urandom); D_num = 1'($urandom); S_num = 1'($urandom); Par = 2'($urandom);
  endtask

  // Returns at posedge+#1 of the cycle in which tx_done is high.
  task automatic wait_done();
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (tx_done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  // Baud tick generator.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk); #1;
      if (tick_div == 0) begin
        bd_tick = ($urandom_range(0, 2) == 0);
      end else begin
        c++;
        if (c >= tick_div) begin bd_tick = 1'b1; c = 0; end
        else bd_tick = 1'b0;
      end
    end
  end

  // Line monitor: 16 tick samples form one bit; tx_done closes a frame.
  initial begin
    int samp;
    int ones;
    int ticks;
    bit e;
    samp = 0; ones = 0; ticks = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        samp = 0; ones = 0; ticks = 0;
      end else begin
        if (is_active && bd_tick) begin
          samp++; ticks++;
          if (tx === 1'b1) ones++;
          if (samp == 16) begin
            if (exp_bits.size() == 0) begin
              check("unexpected_bit", 1, 0);
            end else begin
              e = exp_bits.pop_front();
              check("bit_level_ones", ones, e ? 16 : 0);
            end
            samp = 0; ones = 0;
          end
        end
        if (tx_done === 1'b1) begin
          if (exp_len.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            check("frame_ticks", ticks, exp_len.pop_front());
            check("partial_bit", samp, 0);
          end
          check("done_idle_line", {is_active, tx}, 2'b01);
          ticks = 0; samp = 0; ones = 0;
        end
      end
    end
  end

  initial begin
    int t;
    logic seen;
    logic [7:0] lb [4];
    lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hFF; lb[3] = 8'h3C;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_done", tx_done, 0);
    check("reset_active", is_active, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed formats: 8N1, 8E2, 7O1.
    tick_div = 4;
    send(8'hA5, 1'b1, 1'b0, 2'b00); wait_done(); @(posedge clk); #1;
    send(8'h07, 1'b1, 1'b1, 2'b01); wait_done(); @(posedge clk); #1;
    send(8'hFF, 1'b0, 1'b0, 2'b10); wait_done(); @(posedge clk); #1;

    // A start request mid-DATA is ignored and never replayed.
    send(8'h3C, 1'b1, 1'b0, 2'b11);
    repeat (200) @(posedge clk);
    #1;
    d_in = 8'h00; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_done();
    seen = 1'b0;
    repeat (1200) begin @(posedge clk); #1; seen = seen | is_active; end
    check("no_second_frame", seen, 0);

    // Reset after tick 50 of a frame.
    send(8'h96, 1'b1, 1'b0, 2'b01);
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      if (bd_tick) t++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_bits.delete();
    exp_len.delete();
    @(posedge clk); #1;
    check("midrst_tx", tx, 1);
    check("midrst_active", is_active, 0);
    check("midrst_done", tx_done, 0);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    send(8'h5A, 1'b1, 1'b0, 2'b10); wait_done(); @(posedge clk); #1;

    // Back-to-back 8E2 frames; a start in the done cycle is dropped.
    tick_div = 3;
    send(lb[0], 1'b1, 1'b1, 2'b01);
    for (int i = 1; i < 4; i++) begin
      wait_done();
      d_in = ~lb[i]; D_num = 1'b0; tx_start = 1'b1;
      @(posedge clk); #1;
      send(lb[i], 1'b1, 1'b1, 2'b01);
    end
    wait_done(); @(posedge clk); #1;

    // Randomized formats, data, tick patterns and gaps.
    for (int k = 0; k < 16; k++) begin
      tick_div = $urandom_range(0, 5);
      send(8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      wait_done();
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
    end

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_bits.size() + exp_len.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
